// File: rtl/tff_bank_ctrl_pkg.sv
// Shared types and constants for the TFF bank load controller.
package tff_bank_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles on the rising edge when t is high, async active-low clear.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_bank_ctrl.sv
// Drives a bank of T flip-flops to a requested target using toggle-only access.
// Serial (one bit per cycle, LSB first) by default; TFF_BANK_CTRL_PARALLEL_EN does all bits in one cycle.
module tff_bank_ctrl
  import tff_bank_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] target,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  toggle_cnt,
  output state_t           state_dbg
);

  // Handshake: a request is taken on any rising edge where start_valid and
  // start_ready are both high; start_ready is high only in IDLE, and requests
  // presented while not ready are dropped, not queued.

  state_t           state;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] t;

  assign state_dbg = state;

`ifdef TFF_BANK_CTRL_PARALLEL_EN
  logic [CNTW-1:0] pop;

  always_comb begin
    t = '0;
    if (state == SCAN && !abort) begin
      t = q ^ tgt_r;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + CNTW'(q[i] ^ tgt_r[i]);
    end
  end
`else
  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IDXW-1:0] idx;
  logic [CNTW-1:0] cnt;
  logic            t_sel;
  logic            last;

  // Only the bit under the index is ever allowed to toggle.
  assign t_sel = q[idx] ^ tgt_r[idx];
  assign last  = (idx == IDXW'(WIDTH - 1));

  always_comb begin
    t = '0;
    if (state == SCAN && !abort) begin
      t[idx] = t_sel;
    end
  end
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      toggle_cnt  <= '0;
      tgt_r       <= '0;
`ifndef TFF_BANK_CTRL_PARALLEL_EN
      idx         <= '0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start_valid && start_ready) begin
            tgt_r       <= target;
            state       <= SCAN;
            start_ready <= 1'b0;
            busy        <= 1'b1;
`ifndef TFF_BANK_CTRL_PARALLEL_EN
            idx         <= '0;
            cnt         <= '0;
`endif
          end
        end
        SCAN: begin
          if (abort) begin
            // Partial q stays as-is and toggle_cnt keeps the last completed result.
            state       <= IDLE;
            start_ready <= 1'b1;
            busy        <= 1'b0;
`ifdef TFF_BANK_CTRL_PARALLEL_EN
          end else begin
            toggle_cnt <= pop;
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
`else
          end else if (last) begin
            toggle_cnt <= cnt + CNTW'(t_sel);
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            cnt <= cnt + CNTW'(t_sel);
            idx <= idx + IDXW'(1);
          end
`endif
        end
        DONE: begin
          done        <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// Bench for tff_bank_ctrl (WIDTH=8): vector table, corner-case sequences and a randomized model check.
module tb_tff_bank_ctrl;
  import tff_bank_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

`ifdef TFF_BANK_CTRL_PARALLEL_EN
  localparam int SCAN_LEN = 1;
  localparam int ABORT_AT = 1;
  localparam logic [7:0] EXP_ABORT_Q = 8'h00;
  localparam logic [3:0] EXP_LAST_CNT = 4'd8;
`else
  localparam int SCAN_LEN = 8;
  localparam int ABORT_AT = 3;
  localparam logic [7:0] EXP_ABORT_Q = 8'h03;
  localparam logic [3:0] EXP_LAST_CNT = 4'd6;
`endif

  // Clock / reset
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [WIDTH-1:0] target = '0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  toggle_cnt;
  state_t           state_dbg;

  always #5 clk = ~clk;

  tff_bank_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .target      (target),
    .abort       (abort),
    .q           (q),
    .busy        (busy),
    .done        (done),
    .toggle_cnt  (toggle_cnt),
    .state_dbg   (state_dbg)
  );

  // Scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] m_q;
  logic [3:0] m_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_q"}, 32'(q), 32'h0);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_ready"}, 32'(start_ready), 32'h1);
    check({name, "_done"}, 32'(done), 32'h0);
    check({name, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  // Driver: one request, optional abort in SCAN cycle abort_at (1-based, 0 = none).
  task automatic do_op(input logic [7:0] tg, input int abort_at,
                       output bit saw_done, output int lat);
    int guard;
    bit finished;
    guard = 0;
    while (!start_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", 32'(start_ready), 32'h1);
    start_valid = 1'b1;
    target = tg;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    target = 8'($urandom);
    saw_done = 1'b0;
    lat = 0;
    finished = 1'b0;
    for (int c = 1; c <= 40 && !finished; c++) begin
      abort = (c == abort_at);
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      if (done) begin
        saw_done = 1'b1;
        lat = c;
        finished = 1'b1;
        check("done_busy", 32'(busy), 32'h0);
        check("done_ready", 32'(start_ready), 32'h0);
      end else if (start_ready) begin
        lat = c;
        finished = 1'b1;
      end
    end
    check("op_timeout", 32'(finished), 32'h1);
    if (saw_done) begin
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'h0);
      check("ready_after_done", 32'(start_ready), 32'h1);
    end
  endtask

  typedef struct {
    logic [7:0] tg;
    int         abort_at;
    logic [7:0] exp_q;
    logic [3:0] exp_cnt;
    bit         exp_done;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit saw_done;
    int lat;
    int guard;
    int abort_at;
    logic [7:0] tg;
    logic [7:0] mask;
    logic [7:0] exp_q;
    logic [3:0] exp_cnt;

    tbl[0] = '{8'hA5, 0, 8'hA5, 4'd4, 1'b1};
    tbl[1] = '{8'hA5, 0, 8'hA5, 4'd0, 1'b1};
    tbl[2] = '{8'h5A, 0, 8'h5A, 4'd8, 1'b1};
    tbl[3] = '{8'h00, 0, 8'h00, 4'd4, 1'b1};
    tbl[4] = '{8'hFF, ABORT_AT, EXP_ABORT_Q, 4'd4, 1'b0};
    tbl[5] = '{8'hFF, 0, 8'hFF, EXP_LAST_CNT, 1'b1};

    #12;
    check_idle_outputs("reset");
    check("reset_cnt", 32'(toggle_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven operations
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].tg, tbl[i].abort_at, saw_done, lat);
      check($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].exp_q));
      check($sformatf("tbl%0d_cnt", i), 32'(toggle_cnt), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_done", i), 32'(saw_done), 32'(tbl[i].exp_done));
      check($sformatf("tbl%0d_lat", i), 32'(lat),
            32'(tbl[i].abort_at != 0 ? tbl[i].abort_at : SCAN_LEN));
    end
    m_q = 8'hFF;
    m_cnt = EXP_LAST_CNT;

    // Edge-by-edge progression A5 -> 5A, LSB first
    do_op(8'hA5, 0, saw_done, lat);
    check("pre_edge_q", 32'(q), 32'hA5);
    start_valid = 1'b1;
    target = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    for (int k = 1; k <= SCAN_LEN; k++) begin
      @(posedge clk);
      @(negedge clk);
      mask = (k >= SCAN_LEN) ? 8'hFF : 8'((1 << k) - 1);
      check($sformatf("edge%0d_q", k), 32'(q), 32'((8'hA5 & ~mask) | (8'h5A & mask)));
    end
    check("edge_done", 32'(done), 32'h1);
    check("edge_cnt", 32'(toggle_cnt), 32'd8);
    @(negedge clk);

    // start_valid while busy is dropped; the held request is taken once ready
    start_valid = 1'b1;
    target = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    target = 8'hF0;
    guard = 0;
    while (!done && guard < 40) begin
      check("ignore_ready_low", 32'(start_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    check("ignore_done", 32'(done), 32'h1);
    check("ignore_q", 32'(q), 32'h0F);
    check("ignore_cnt", 32'(toggle_cnt), 32'd4);
    @(negedge clk);
    check("ignore_ready_next", 32'(start_ready), 32'h1);
    @(negedge clk);
    check("reaccept_busy", 32'(busy | done), 32'h1);
    start_valid = 1'b0;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("reaccept_done", 32'(done), 32'h1);
    check("reaccept_q", 32'(q), 32'hF0);
    check("reaccept_cnt", 32'(toggle_cnt), 32'd8);
    @(negedge clk);

    // Asynchronous reset in the middle of SCAN
    start_valid = 1'b1;
    target = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    if (SCAN_LEN > 1) begin
      @(posedge clk);
      @(negedge clk);
      check("mid_reset_busy", 32'(busy), 32'h1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_cnt", 32'(toggle_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < SCAN_LEN + 2; k++) begin
      @(negedge clk);
      check("post_reset_no_done", 32'(done), 32'h0);
    end
    m_q = 8'h00;
    m_cnt = 4'd0;

    // Randomized operations against a behavioural model
    for (int n = 0; n < 40; n++) begin
      tg = 8'($urandom);
      abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, SCAN_LEN)) : 0;
      mask = (abort_at != 0) ? 8'((1 << (abort_at - 1)) - 1) : 8'hFF;
      exp_q = (m_q & ~mask) | (tg & mask);
      exp_cnt = (abort_at != 0) ? m_cnt : 4'($countones((m_q ^ tg) & mask));
      do_op(tg, abort_at, saw_done, lat);
      check($sformatf("rnd%0d_q", n), 32'(q), 32'(exp_q));
      check($sformatf("rnd%0d_cnt", n), 32'(toggle_cnt), 32'(exp_cnt));
      check($sformatf("rnd%0d_done", n), 32'(saw_done), 32'(abort_at == 0));
      check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(abort_at != 0 ? abort_at : SCAN_LEN));
      m_q = exp_q;
      m_cnt = exp_cnt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
